// File: rtl/add_sub_hls_deadlock_reporter_if.sv
// Handshake bundle between an HLS deadlock monitor and the deadlock reporter.
// The reporter connects as slave; the monitored side or a bench connects as master.
interface add_sub_hls_deadlock_reporter_if;
   logic       block_in;
   logic [2:0] axis_block_sigs;
   logic       inst_idle;
   logic       report_ack;
   logic       report_valid;
   logic [2:0] report_chan;
   logic       deadlock_detected;
   logic [7:0] event_count;

   modport slave (
      input  block_in,
      input  axis_block_sigs,
      input  inst_idle,
      input  report_ack,
      output report_valid,
      output report_chan,
      output deadlock_detected,
      output event_count
   );

   modport master (
      output block_in,
      output axis_block_sigs,
      output inst_idle,
      output report_ack,
      input  report_valid,
      input  report_chan,
      input  deadlock_detected,
      input  event_count
   );
endinterface

// File: rtl/add_sub_hls_deadlock_reporter.sv
// Declares a deadlock after THRESHOLD consecutive blocked, non-idle cycles and holds a report until acked.
// Define ADD_SUB_HLS_DEADLOCK_EVENT_CNT_EN to build the saturating 8-bit deadlock event counter.
module add_sub_hls_deadlock_reporter #(
   parameter int THRESHOLD = 1024,
   parameter int CNT_W     = 16
) (
   input logic                                 clk,
   input logic                                 rst,
   add_sub_hls_deadlock_reporter_if.slave      mon_if
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      REPORT = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       report_chan_q;
   logic             report_valid_q;
   logic             deadlock_q;
   logic             qualify;
   logic             go_report;

   // Only a blocked instance that is actually busy counts towards a deadlock.
   assign qualify   = mon_if.block_in & ~mon_if.inst_idle;
   assign go_report = (state_q == COUNT) && qualify && (cnt_q == CNT_LAST);
   assign cnt_d     = cnt_q + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         report_chan_q  <= 3'b000;
         report_valid_q <= 1'b0;
         deadlock_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (qualify) begin
                  state_q <= COUNT;
                  cnt_q   <= CNT_W'(1);
               end else begin
                  cnt_q   <= '0;
               end
            end
            COUNT: begin
               if (!qualify) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (go_report) begin
                  state_q        <= REPORT;
                  cnt_q          <= '0;
                  report_chan_q  <= mon_if.axis_block_sigs;
                  report_valid_q <= 1'b1;
                  deadlock_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            // The report stays pending even if the block clears; only an ack releases it.
            REPORT: begin
               if (mon_if.report_ack) begin
                  state_q        <= HOLD;
                  report_valid_q <= 1'b0;
               end
            end
            HOLD: begin
               if (!mon_if.block_in) begin
                  state_q    <= IDLE;
                  cnt_q      <= '0;
                  deadlock_q <= 1'b0;
               end
            end
            default: begin
               state_q        <= IDLE;
               cnt_q          <= '0;
               report_valid_q <= 1'b0;
               deadlock_q     <= 1'b0;
            end
         endcase
      end
   end

   assign mon_if.report_valid      = report_valid_q;
   assign mon_if.report_chan       = report_chan_q;
   assign mon_if.deadlock_detected = deadlock_q;

`ifdef ADD_SUB_HLS_DEADLOCK_EVENT_CNT_EN
   logic [7:0] event_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_cnt_q <= 8'd0;
      end else if (go_report && (event_cnt_q != 8'hFF)) begin
         event_cnt_q <= event_cnt_q + 8'd1;
      end
   end

   assign mon_if.event_count = event_cnt_q;
`else
   assign mon_if.event_count = 8'd0;
`endif

endmodule

// File: tb/tb_add_sub_hls_deadlock_reporter.sv
// Directed, table-driven bench for the deadlock reporter at THRESHOLD=4,
// plus hand sequences for asynchronous reset and event counter saturation.
module tb_add_sub_hls_deadlock_reporter;

   localparam int THRESHOLD = 4;
`ifdef ADD_SUB_HLS_DEADLOCK_EVENT_CNT_EN
   localparam bit EV_EN = 1'b1;
`else
   localparam bit EV_EN = 1'b0;
`endif

   typedef struct {
      logic       b;
      logic       idl;
      logic [2:0] sigs;
      logic       ack;
      logic       v;
      logic       d;
      logic [2:0] ch;
      int         ev;
   } vec_t;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   vec_t vq[$];

   add_sub_hls_deadlock_reporter_if dut_if ();

   add_sub_hls_deadlock_reporter #(
      .THRESHOLD (THRESHOLD),
      .CNT_W     (16)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .mon_if (dut_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic b, input logic idl, input logic [2:0] sigs, input logic ack);
      dut_if.block_in        = b;
      dut_if.inst_idle       = idl;
      dut_if.axis_block_sigs = sigs;
      dut_if.report_ack      = ack;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic b, input logic idl, input logic [2:0] sigs, input logic ack,
                      input logic v, input logic d, input logic [2:0] ch, input int ev);
      vec_t t;
      t.b = b; t.idl = idl; t.sigs = sigs; t.ack = ack;
      t.v = v; t.d = d; t.ch = ch; t.ev = ev;
      vq.push_back(t);
   endtask

   task automatic chk_outs(input string tag, input logic v, input logic d, input logic [2:0] ch, input int ev);
      chk({tag, ".valid"}, 32'(dut_if.report_valid), 32'(v));
      chk({tag, ".det"},   32'(dut_if.deadlock_detected), 32'(d));
      chk({tag, ".chan"},  32'(dut_if.report_chan), 32'(ch));
      chk({tag, ".evcnt"}, 32'(dut_if.event_count), EV_EN ? 32'(ev) : 32'd0);
   endtask

   // Reset lands between clock edges; outputs must clear before any edge arrives.
   task automatic async_reset(input string tag);
      #3 rst = 1'b1;
      #1 chk_outs(tag, 1'b0, 1'b0, 3'b000, 0);
      $display("[TB] %s: async reset applied valid=%0b det=%0b chan=%03b", tag,
               dut_if.report_valid, dut_if.deadlock_detected, dut_if.report_chan);
      #1 rst = 1'b0;
   endtask

   initial begin
      int got;
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      drive(1'b0, 1'b0, 3'b000, 1'b0);
      #1 chk_outs("reset", 1'b0, 1'b0, 3'b000, 0);
      #6 rst = 1'b0;

      // Basic detection, hold-through-unblock, late ack, HOLD->IDLE
      for (int i = 0; i < 3; i++) add(1, 0, 3'b010, 0, 0, 0, 3'b000, 0);
      add(1, 0, 3'b010, 0, 1, 1, 3'b010, 1);
      add(1, 0, 3'b101, 0, 1, 1, 3'b010, 1);
      for (int i = 0; i < 5; i++) add(0, 0, 3'b000, 0, 1, 1, 3'b010, 1);
      add(0, 0, 3'b000, 1, 0, 1, 3'b010, 1);
      add(0, 0, 3'b000, 0, 0, 0, 3'b010, 1);
      add(0, 0, 3'b000, 1, 0, 0, 3'b010, 1);
      // inst_idle aborts a count; fresh count then reports; ack while blocked -> HOLD
      for (int i = 0; i < 3; i++) add(1, 0, 3'b001, 0, 0, 0, 3'b010, 1);
      add(1, 1, 3'b001, 0, 0, 0, 3'b010, 1);
      for (int i = 0; i < 3; i++) add(1, 0, 3'b001, 0, 0, 0, 3'b010, 1);
      add(1, 0, 3'b001, 0, 1, 1, 3'b001, 2);
      add(1, 0, 3'b001, 1, 0, 1, 3'b001, 2);
      add(1, 0, 3'b001, 0, 0, 1, 3'b001, 2);
      add(0, 0, 3'b000, 0, 0, 0, 3'b001, 2);
      // 3 blocked, 1 clear, 3 blocked: no report; the 4th after the drop reports
      for (int i = 0; i < 3; i++) add(1, 0, 3'b110, 0, 0, 0, 3'b001, 2);
      add(0, 0, 3'b110, 0, 0, 0, 3'b001, 2);
      for (int i = 0; i < 3; i++) add(1, 0, 3'b110, 0, 0, 0, 3'b001, 2);
      add(1, 0, 3'b110, 0, 1, 1, 3'b110, 3);
      add(0, 0, 3'b000, 1, 0, 1, 3'b110, 3);
      add(0, 0, 3'b000, 0, 0, 0, 3'b110, 3);

      foreach (vq[k]) begin
         drive(vq[k].b, vq[k].idl, vq[k].sigs, vq[k].ack);
         step();
         $display("[TB] vec %0d b=%0b idle=%0b sigs=%03b ack=%0b -> valid=%0b det=%0b chan=%03b ev=%0d",
                  k, vq[k].b, vq[k].idl, vq[k].sigs, vq[k].ack, dut_if.report_valid,
                  dut_if.deadlock_detected, dut_if.report_chan, dut_if.event_count);
         chk_outs($sformatf("vec%0d", k), vq[k].v, vq[k].d, vq[k].ch, vq[k].ev);
      end

      // Reset mid-COUNT (cnt=3): the count is discarded and 4 fresh edges are needed
      drive(1'b1, 1'b0, 3'b011, 1'b0);
      for (int i = 0; i < 3; i++) step();
      chk("midcount.pre_valid", 32'(dut_if.report_valid), 32'd0);
      async_reset("midcount");
      for (int i = 1; i <= 4; i++) begin
         step();
         $display("[TB] fresh edge %0d valid=%0b det=%0b chan=%03b", i,
                  dut_if.report_valid, dut_if.deadlock_detected, dut_if.report_chan);
         if (i < 4) chk($sformatf("fresh%0d.valid", i), 32'(dut_if.report_valid), 32'd0);
      end
      chk_outs("fresh4", 1'b1, 1'b1, 3'b011, 1);
      drive(1'b0, 1'b0, 3'b000, 1'b1);
      step();
      drive(1'b0, 1'b0, 3'b000, 1'b0);
      step();
      chk_outs("fresh.idle", 1'b0, 1'b0, 3'b011, 1);

      // Reset mid-REPORT: the pending report vanishes and nothing reappears
      drive(1'b1, 1'b0, 3'b100, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("midreport.pre_valid", 32'(dut_if.report_valid), 32'd1);
      async_reset("midreport");
      drive(1'b0, 1'b0, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) step();
      chk_outs("midreport.after", 1'b0, 1'b0, 3'b000, 0);
      $display("[TB] midreport after 3 idle edges valid=%0b det=%0b", dut_if.report_valid,
               dut_if.deadlock_detected);

      // 300 back-to-back events; each wait for report_valid is bounded
      got = 0;
      for (int n = 1; n <= 300; n++) begin
         bit seen;
         seen = 1'b0;
         drive(1'b1, 1'b0, 3'b111, 1'b0);
         for (int c = 0; c < 8 && !seen; c++) begin
            step();
            seen = dut_if.report_valid;
         end
         if (seen) got++;
         drive(1'b0, 1'b0, 3'b000, 1'b1);
         step();
         drive(1'b0, 1'b0, 3'b000, 1'b0);
         step();
         if (n == 254 || n == 255 || n == 300) begin
            $display("[TB] event %0d event_count=%0d", n, dut_if.event_count);
            chk($sformatf("evcnt_at_%0d", n), 32'(dut_if.event_count),
                EV_EN ? 32'(n > 255 ? 255 : n) : 32'd0);
         end
      end
      chk("all_events_reported", 32'(got), 32'd300);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/add_sub_hls_deadlock_reporter.md
ADD_SUB_HLS_DEADLOCK_REPORTER -- requirements
Module: add_sub_hls_deadlock_reporter

Interface
REQ-001 Parameter THRESHOLD, default 1024, SHALL set the number of consecutive blocked cycles that declares a deadlock; legal range 2..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the blocked-cycle counter.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 block_in  input  1  SHALL carry the block output of the per-instance deadlock monitor.
REQ-006 axis_block_sigs  input  3  SHALL carry the per-channel AXIS block flags used for the monitor.
REQ-007 inst_idle  input  1  SHALL indicate that the monitored instance is idle.
REQ-008 report_ack  input  1  SHALL acknowledge a pending report.
REQ-009 report_valid  output  1  SHALL indicate that a deadlock report is pending.
REQ-010 report_chan  output  3  SHALL carry the AXIS channels blocked at detection.
REQ-011 deadlock_detected  output  1  SHALL be high from detection until the block clears after acknowledge.
REQ-012 event_count  output  8  SHALL carry the deadlock event count (see Configuration).

Function
REQ-013 The block SHALL implement the states IDLE, COUNT, REPORT and HOLD, with a CNT_W-bit counter cnt.
REQ-014 IDLE: cnt=0; on block_in=1 and inst_idle=0 SHALL go to COUNT with cnt=1; otherwise SHALL stay.
REQ-015 COUNT: on block_in=0 or inst_idle=1 SHALL return to IDLE with cnt=0 on that edge.
REQ-016 COUNT: on block_in=1, inst_idle=0 and cnt<THRESHOLD-1 SHALL increment cnt.
REQ-017 COUNT: on block_in=1, inst_idle=0 and cnt==THRESHOLD-1 SHALL go to REPORT and capture report_chan<=axis_block_sigs on that edge.
REQ-018 report_valid SHALL rise on the edge at which the THRESHOLD-th consecutive qualifying block_in=1 sample is taken.
REQ-019 REPORT: report_valid=1, deadlock_detected=1, and report_chan SHALL be held stable.
REQ-020 REPORT: SHALL remain in REPORT until report_ack=1 is sampled, even if block_in falls first; ack then SHALL move to HOLD.
REQ-021 report_ack sampled outside REPORT SHALL be ignored.
REQ-022 HOLD: report_valid=0, deadlock_detected=1; on block_in=0 SHALL go to IDLE with cnt=0, and report_chan SHALL be retained.
REQ-023 deadlock_detected SHALL be 0 in IDLE and COUNT.
REQ-024 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-025 Assertion of reset SHALL immediately force the state to IDLE and cnt=0, independent of clock.
REQ-026 While reset is asserted, report_valid=0, deadlock_detected=0, report_chan=3'b000 and event_count=8'd0.
REQ-027 Reset asserted mid-COUNT or mid-REPORT SHALL discard the pending count and report; no report is generated afterwards.
REQ-028 After deassertion, the first qualifying sample SHALL start a fresh count from 1.

Configuration
REQ-029 With ADD_SUB_HLS_DEADLOCK_EVENT_CNT_EN defined, event_count SHALL increment on each COUNT->REPORT transition and saturate at 255.
REQ-030 Without ADD_SUB_HLS_DEADLOCK_EVENT_CNT_EN, event_count SHALL be tied to 8'd0 and the counter logic SHALL be absent; all other behaviour is identical.

Verification (THRESHOLD=4)
REQ-031 Hold block_in=1, inst_idle=0, axis_block_sigs=3'b010 for 4 edges -> report_valid=1 and deadlock_detected=1 after the 4th edge; report_chan=3'b010.
REQ-032 Drive block_in=1 for 3 edges, then 0 for 1 edge, then 1 for 3 edges -> report_valid is never asserted and cnt returns to 0 at the drop.
REQ-033 In REPORT, drop block_in, then pulse report_ack 5 cycles later -> report_valid stays 1 until the ack edge, then IDLE on the following edge with deadlock_detected=0.
REQ-034 In REPORT, ack with block_in=1 held -> HOLD with report_valid=0 and deadlock_detected=1; then block_in=0 -> IDLE.
REQ-035 Apply async reset between edges while in COUNT with cnt=3 -> outputs are 0 immediately; block_in=1 then needs 4 fresh edges to report.
REQ-036 With the macro defined, 300 back-to-back deadlock events -> event_count=255; without the macro -> event_count=0.
